wb_arbiter2: RTL and testbench

//   Two-master, one-slave Wishbone B4 classic arbiter for the on-chip 32-bit SRAM (four 16Kx8 byte lanes).

---
 rtl/wb_arbiter2.sv | 143 ++++++++++++++
 tb/tb_wb_arbiter2.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master round-robin Wishbone B4 classic arbiter; the grant is held per CYC burst.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that turns a missing slave ACK into ERR.
module wb_arbiter2 #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_m0_cyc,
  input  logic            i_m0_stb,
  input  logic            i_m0_we,
  input  logic [AW-1:0]   i_m0_adr,
  input  logic [DW-1:0]   i_m0_dat,
  input  logic [DW/8-1:0] i_m0_sel,
  output logic [DW-1:0]   o_m0_dat,
  output logic            o_m0_ack,
  output logic            o_m0_err,
  input  logic            i_m1_cyc,
  input  logic            i_m1_stb,
  input  logic            i_m1_we,
  input  logic [AW-1:0]   i_m1_adr,
  input  logic [DW-1:0]   i_m1_dat,
  input  logic [DW/8-1:0] i_m1_sel,
  output logic [DW-1:0]   o_m1_dat,
  output logic            o_m1_ack,
  output logic            o_m1_err,
  output logic            o_s_cyc,
  output logic            o_s_stb,
  output logic            o_s_we,
  output logic [AW-1:0]   o_s_adr,
  output logic [DW-1:0]   o_s_dat,
  output logic [DW/8-1:0] o_s_sel,
  input  logic [DW-1:0]   i_s_dat,
  input  logic            i_s_ack,
  input  logic            i_s_err,
  output logic [1:0]      o_grant
);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e     state_q;
  logic       last_owner_q;  // 0: m0 owned the bus last, 1: m1
  logic [1:0] grant_q;
  logic       timeout;
  logic       own_stb;

  assign own_stb = (state_q == StGnt1) ? i_m1_stb : i_m0_stb;

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] wdog_q;

  assign timeout = (state_q != StIdle) && (wdog_q == 16'(TIMEOUT));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wdog_q <= '0;
    end else if (state_q == StIdle || i_s_ack || i_s_err || timeout) begin
      wdog_q <= '0;
    end else if (own_stb) begin
      wdog_q <= wdog_q + 16'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^16'(TIMEOUT);
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= StIdle;
      last_owner_q <= 1'b1;
      grant_q      <= 2'b00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_m0_cyc && (!i_m1_cyc || last_owner_q)) begin
            state_q <= StGnt0;
            grant_q <= 2'b01;
          end else if (i_m1_cyc) begin
            state_q <= StGnt1;
            grant_q <= 2'b10;
          end
        end
        StGnt0: begin
          if (!i_m0_cyc || timeout) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b0;
            grant_q      <= 2'b00;
          end
        end
        StGnt1: begin
          if (!i_m1_cyc || timeout) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b1;
            grant_q      <= 2'b00;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  assign o_grant  = grant_q;
  assign o_m0_dat = i_s_dat;
  assign o_m1_dat = i_s_dat;

  // Slave bus follows the owner combinationally so a reset drops CYC/STB at once.
  always_comb begin
    o_s_cyc  = 1'b0;
    o_s_stb  = 1'b0;
    o_s_we   = 1'b0;
    o_s_adr  = (state_q == StGnt1) ? i_m1_adr : i_m0_adr;
    o_s_dat  = (state_q == StGnt1) ? i_m1_dat : i_m0_dat;
    o_s_sel  = (state_q == StGnt1) ? i_m1_sel : i_m0_sel;
    o_m0_ack = 1'b0;
    o_m0_err = 1'b0;
    o_m1_ack = 1'b0;
    o_m1_err = 1'b0;
    unique case (state_q)
      StGnt0: begin
        o_s_cyc  = i_m0_cyc & ~timeout;
        o_s_stb  = own_stb & ~timeout;
        o_s_we   = i_m0_we;
        o_m0_ack = i_s_ack & ~timeout;
        o_m0_err = i_s_err | timeout;
      end
      StGnt1: begin
        o_s_cyc  = i_m1_cyc & ~timeout;
        o_s_stb  = own_stb & ~timeout;
        o_s_we   = i_m1_we;
        o_m1_ack = i_s_ack & ~timeout;
        o_m1_err = i_s_err | timeout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Testbench for wb_arbiter2: directed scenarios, then randomized masters/slave against a
// cycle-level reference model whose expectations are queued and checked by a monitor.
module tb_wb_arbiter2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 8;

  typedef struct {
    logic [1:0]    grant;
    bit            owned;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    logic [1:0]    ack, err;
    logic [DW-1:0] rdat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
  logic [AW-1:0] m_adr [2];
  logic [DW-1:0] m_dat [2];
  logic [SW-1:0] m_sel [2];
  logic [DW-1:0] m0_rdat, m1_rdat, s_rdat = '0;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_wdat;
  logic [SW-1:0] s_sel;
  logic          s_ack = 1'b0, s_err = 1'b0;
  logic [1:0]    grant;

  int n_chk = 0;
  int n_fail = 0;
  exp_t exp_q[$];

  // Reference model state
  int owner, last, wcnt, swait, starget;
  bit fire, prev_stb;
  bit got_ack [2];
  bit got_err [2];
  int beats [2];
  int done [2];

  wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_cyc(m_cyc[0]), .i_m0_stb(m_stb[0]), .i_m0_we(m_we[0]), .i_m0_adr(m_adr[0]),
    .i_m0_dat(m_dat[0]), .i_m0_sel(m_sel[0]),
    .o_m0_dat(m0_rdat), .o_m0_ack(m0_ack), .o_m0_err(m0_err),
    .i_m1_cyc(m_cyc[1]), .i_m1_stb(m_stb[1]), .i_m1_we(m_we[1]), .i_m1_adr(m_adr[1]),
    .i_m1_dat(m_dat[1]), .i_m1_sel(m_sel[1]),
    .o_m1_dat(m1_rdat), .o_m1_ack(m1_ack), .o_m1_err(m1_err),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_adr(s_adr), .o_s_dat(s_wdat),
    .o_s_sel(s_sel), .i_s_dat(s_rdat), .i_s_ack(s_ack), .i_s_err(s_err),
    .o_grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_beat(input int i);
    m_stb[i] = ($urandom_range(3) != 0);
    m_we[i]  = $urandom_range(1);
    m_adr[i] = $urandom & ~32'h3;
    m_dat[i] = $urandom;
    m_sel[i] = 4'($urandom);
  endtask

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0; s_err = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_adr[i] = '0; m_dat[i] = '0; m_sel[i] = '0;
      got_ack[i] = 0; got_err[i] = 0; beats[i] = 0;
    end
  endtask

  // One random cycle: advance the model on the edge, drive new stimulus, queue expectations.
  task automatic step();
    exp_t e;
    bit   stb_raw;
    tick();
    // Arbitration uses what was on the bus during the cycle that just ended
    if (owner < 0) begin
      if (m_cyc[0] && m_cyc[1]) owner = 1 - last;
      else if (m_cyc[0]) owner = 0;
      else if (m_cyc[1]) owner = 1;
      wcnt = 0;
    end else if (!m_cyc[owner] || fire) begin
      last  = owner;
      owner = -1;
      wcnt  = 0;
    end else if (s_ack || s_err) begin
      wcnt = 0;
    end else if (m_stb[owner]) begin
      wcnt++;
    end
    if (prev_stb && !s_ack && !s_err && !fire) begin
      swait++;
    end else begin
      swait   = 0;
      starget = ($urandom_range(9) == 0) ? 12 : $urandom_range(3);
    end
    for (int i = 0; i < 2; i++) begin
      if (m_cyc[i]) begin
        if (got_ack[i] || got_err[i]) begin
          beats[i]--;
          if (got_err[i] || beats[i] == 0) begin
            m_cyc[i] = 1'b0; m_stb[i] = 1'b0; done[i]++;
          end else begin
            new_beat(i);
          end
        end else if (owner != i && $urandom_range(15) == 0) begin
          m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
        end else if (!m_stb[i]) begin
          m_stb[i] = $urandom_range(1);
        end
      end else if ($urandom_range(3) == 0) begin
        m_cyc[i] = 1'b1;
        beats[i] = $urandom_range(1, 4);
        new_beat(i);
      end
    end
    stb_raw = (owner >= 0) && m_cyc[owner] && m_stb[owner];
    s_ack  = 1'b0;
    s_err  = 1'b0;
    s_rdat = $urandom;
    if (stb_raw && swait >= starget) begin
      if ($urandom_range(7) == 0) begin
        s_err = 1'b1; s_ack = $urandom_range(1);
      end else begin
        s_ack = 1'b1;
      end
    end
`ifdef WB_ARB_TIMEOUT_EN
    fire = (owner >= 0) && (wcnt == TO);
`else
    fire = 0;
`endif
    e.grant = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    e.owned = (owner >= 0);
    e.s_cyc = 1'b0; e.s_stb = 1'b0; e.s_we = 1'b0;
    e.adr = '0; e.dat = '0; e.sel = '0; e.ack = 2'b00; e.err = 2'b00;
    e.rdat = s_rdat;
    if (owner >= 0) begin
      e.s_cyc = m_cyc[owner] && !fire;
      e.s_stb = m_stb[owner] && !fire;
      e.s_we  = m_we[owner];
      e.adr   = m_adr[owner];
      e.dat   = m_dat[owner];
      e.sel   = m_sel[owner];
      e.ack[owner] = s_ack && !fire;
      e.err[owner] = s_err || fire;
    end
    for (int i = 0; i < 2; i++) begin
      got_ack[i] = e.ack[i];
      got_err[i] = e.err[i];
    end
    prev_stb = stb_raw;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("grant", grant, e.grant);
      chk("s_cyc", s_cyc, e.s_cyc);
      chk("s_stb", s_stb, e.s_stb);
      chk("ack", {m1_ack, m0_ack}, e.ack);
      chk("err", {m1_err, m0_err}, e.err);
      chk("m0_dat", m0_rdat, e.rdat);
      chk("m1_dat", m1_rdat, e.rdat);
      if (e.owned) begin
        chk("s_we", s_we, e.s_we);
        chk("s_adr", s_adr, e.adr);
        chk("s_dat", s_wdat, e.dat);
        chk("s_sel", s_sel, e.sel);
      end
    end
  end

  initial begin
    clear_inputs();
    #12;
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_cyc", s_cyc, 1'b0);
    chk("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 4'b0);
    @(negedge clk) rst = 1'b0;

    // Single m0 read, one-cycle arbitration latency
    tick();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h0000_0010; m_sel[0] = 4'hF;
    #1 chk("t1_no_grant_yet", grant, 2'b00);
    tick();
    chk("t1_grant", grant, 2'b01);
    chk("t1_s_adr", s_adr, 32'h10);
    chk("t1_s_stb", s_stb, 1'b1);
    s_ack = 1'b1; s_rdat = 32'hDEAD_BEEF;
    #1 chk("t1_m0_ack", m0_ack, 1'b1);
    chk("t1_m0_dat", m0_rdat, 32'hDEAD_BEEF);
    chk("t1_m1_ack", m1_ack, 1'b0);
    tick();
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    #1 chk("t1_s_cyc_drop", s_cyc, 1'b0);
    tick();
    chk("t1_idle", grant, 2'b00);

    // Asynchronous reset while m0 is mid-transfer
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    chk("t4_grant", grant, 2'b01);
    #2 rst = 1'b1;
    #1 chk("t4_async_cyc", s_cyc, 1'b0);
    chk("t4_async_stb", s_stb, 1'b0);
    chk("t4_async_grant", grant, 2'b00);
    @(negedge clk) rst = 1'b0;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick();
    chk("t4_tie_m0", grant, 2'b01);
    m_cyc = '0; m_stb = '0;
    tick();
    chk("t4_idle", grant, 2'b00);

`ifdef WB_ARB_TIMEOUT_EN
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    for (int k = 0; k < TO; k++) begin
      chk("t5_no_err_early", m0_err, 1'b0);
      chk("t5_grant", grant, 2'b01);
      tick();
    end
    chk("t5_err", m0_err, 1'b1);
    chk("t5_cyc_forced", s_cyc, 1'b0);
    chk("t5_stb_forced", s_stb, 1'b0);
    tick();
    chk("t5_err_once", m0_err, 1'b0);
    chk("t5_idle", grant, 2'b00);
    s_ack = 1'b1;
    #1 chk("t5_late_ack", m0_ack, 1'b0);
    m_cyc = '0; m_stb = '0; s_ack = 1'b0;
    tick();
`else
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    repeat (1000) begin
      chk("t6_grant_held", grant, 2'b01);
      chk("t6_no_err", m0_err, 1'b0);
      tick();
    end
    s_err = 1'b1;
    #1 chk("t6_err_pass", m0_err, 1'b1);
    chk("t6_m1_err", m1_err, 1'b0);
    s_err = 1'b0; m_cyc = '0; m_stb = '0;
    tick();
`endif

    // Randomized phase from a clean reset
    clear_inputs();
    rst = 1'b1;
    #3 rst = 1'b0;
    owner = -1; last = 1; wcnt = 0; fire = 0; prev_stb = 0; swait = 0; starget = 0;
    done[0] = 0; done[1] = 0;
    repeat (4000) step();
    @(negedge clk);
    #1;
    chk("m0_progress", done[0] > 0, 1'b1);
    chk("m1_progress", done[1] > 0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
